wavetable_loader: RTL and testbench
===================================

// Module: wavetable_loader
// PURPOSE
//  Write side of the wavetable RAM. Accepts a stream of samples over a valid/ready handshake.
//  Writes one full table (2**ADDRWIDTH entries) into a selected bank through the WADDR/wbank/WDATA/WCLK port.
//  That port mirrors the oscillator's RADDR/rbank/RDATA/RCLK read port.
//  Sits between the host/SPI sample deframer and the RAM write port.
//  Refuses to overwrite the bank the oscillator is currently playing.
// PARAMETERS
//  DATAWIDTH  16  sample / RAM word width
//  ADDRWIDTH  8   table address width; table depth DEPTH = 2**ADDRWIDTH
//  BANKWIDTH  2   bank select width (4 banks)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-high reset
//  start     in   1          1-cycle pulse: begin loading bank bank_sel (honoured only in IDLE)
//  bank_sel  in   BANKWIDTH  target bank, sampled on start
//  abort     in   1          terminate a load in progress
//  rbank     in   BANKWIDTH  bank currently read by the oscillator (protected)
//  s_data    in   DATAWIDTH  incoming sample
//  s_valid   in   1          s_data valid
//  s_ready   out  1          loader can accept s_data this cycle
//  WADDR     out  ADDRWIDTH  RAM write address
//  wbank     out  BANKWIDTH  RAM write bank
//  WDATA     out  DATAWIDTH  RAM write data
//  WCLK      out  1          RAM write strobe; RAM captures on its rising edge
//  busy      out  1          high in LOAD/WRITE
//  done      out  1          1-cycle pulse: full table written
//  err       out  1          1-cycle pulse: start rejected (bank conflict)
// BEHAVIOUR
//  Reset: every output is 0; FSM is IDLE; address counter is 0. No WCLK edge during or after reset.
//  FSM states are IDLE, LOAD, WRITE and DONE; all outputs are registered.
//  IDLE: s_ready=0.
//   On start with bank_sel==rbank: err=1 next cycle, stay IDLE.
//   On start otherwise: latch wbank<=bank_sel, WADDR<=0, go LOAD.
//  LOAD: s_ready=1.
//   On s_valid&&s_ready (cycle N): WDATA<=s_data, go WRITE.
//  WRITE (cycle N+1): WCLK=1, s_ready=0; WADDR, WDATA and wbank are stable since cycle N+1.
//   Next cycle WCLK=0.
//   If WADDR==DEPTH-1, go DONE. Otherwise WADDR<=WADDR+1 and go LOAD.
//   Throughput is 1 sample per 2 clocks; WADDR never changes while WCLK=1.
//  DONE: done=1 for exactly one cycle, then IDLE. WADDR returns to 0 and wbank holds its value.
//  abort has priority over every transition.
//   From LOAD it returns to IDLE immediately, with no done.
//   From WRITE it lets the current WCLK pulse complete, then goes to IDLE.
//  start outside IDLE is ignored, with no err.
//  rbank changing to equal wbank mid-load is not checked. The upstream controller sequences bank swaps only after done.
//  start and abort in the same IDLE cycle: abort wins, no load, no err.
//  WADDR wrap: the counter never wraps during a load. The increment past DEPTH-1 is suppressed.
//  Async reset mid-load clears the FSM to IDLE; the partial table is left in RAM.
// CONFIGURATION
//  WAVETABLE_LOADER_CKSUM_EN defined:
//   Adds input cksum_exp[DATAWIDTH-1:0], sampled on start.
//   Accumulates a mod-2**DATAWIDTH sum of every written WDATA.
//   In DONE, if sum!=cksum_exp, err pulses in the same cycle as done.
//   The sum clears on start.
//  Undefined: no cksum_exp port, no accumulator, and err is driven only by bank conflict.
// STRUCTURE
//  Shared package/include holds the FSM state encodings (IDLE, LOAD, WRITE, DONE) and the DATAWIDTH/ADDRWIDTH/BANKWIDTH defaults.
//  The oscillator uses the same DATAWIDTH/ADDRWIDTH/BANKWIDTH defaults.
//  Single module; no sub-module. The checksum accumulator is an in-module generate block.
// TESTING
//  1. start, bank_sel=1, rbank=0; stream 0..255 with s_valid held -> 256 WCLK pulses, WADDR 0..255, WDATA==WADDR, wbank=1.
//     Followed by done 1 cycle after the last WCLK falls, then busy=0.
//  2. start with bank_sel=2, rbank=2 -> err pulse 1 cycle later, busy=0, no WCLK.
//  3. Stream with s_valid toggling 1/0 randomly -> WADDR still 0..255 contiguous, no duplicate/missed writes.
//     The load completes after 256 accepts.
//  4. abort asserted after 10 writes -> return to IDLE; exactly 10 WCLK pulses; no done.
//     A following start reloads from WADDR=0.
//  5. rst asserted while WCLK=1 -> WCLK, busy, WADDR drop to 0 immediately; no further writes after rst release.
//  6. (CKSUM_EN) stream 256 samples of 16'h0001, cksum_exp=16'h0100 -> done, no err.
//     Same stream with cksum_exp=16'h00FF -> done and err in the same cycle.

Source files
------------

// File: rtl/wavetable_loader_pkg.sv
// Shared definitions for the wavetable write-side loader.
// The oscillator read side uses the same width defaults.
package wavetable_loader_pkg;

  localparam int DATAWIDTH_DEF = 16;
  localparam int ADDRWIDTH_DEF = 8;
  localparam int BANKWIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wavetable_loader.sv
// Streams one full wavetable into a RAM bank, refusing the bank being played.
// Optional build macro WAVETABLE_LOADER_CKSUM_EN adds an end-of-table checksum check.
module wavetable_loader
  import wavetable_loader_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int BANKWIDTH = BANKWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BANKWIDTH-1:0] bank_sel,
  input  logic                 abort,
  input  logic [BANKWIDTH-1:0] rbank,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDRWIDTH-1:0] WADDR,
  output logic [BANKWIDTH-1:0] wbank,
  output logic [DATAWIDTH-1:0] WDATA,
  output logic                 WCLK,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef WAVETABLE_LOADER_CKSUM_EN
  ,
  input  logic [DATAWIDTH-1:0] cksum_exp
`endif
);

  localparam logic [ADDRWIDTH-1:0] ADDR_LAST = {ADDRWIDTH{1'b1}};
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = ADDRWIDTH'(1);

  state_t state;
  logic   cksum_bad;

`ifdef WAVETABLE_LOADER_CKSUM_EN
  if (DATAWIDTH > 0) begin : g_cksum
    logic                 load_go;
    logic                 write_go;
    logic [DATAWIDTH-1:0] sum_acc;
    logic [DATAWIDTH-1:0] sum_exp;

    assign load_go  = (state == ST_IDLE) && start && !abort && (bank_sel != rbank);
    assign write_go = (state == ST_LOAD) && s_valid && s_ready && !abort;

    // Running sum of every accepted sample; the sample accepted here becomes WDATA.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_acc <= '0;
        sum_exp <= '0;
      end else if (load_go) begin
        sum_acc <= '0;
        sum_exp <= cksum_exp;
      end else if (write_go) begin
        sum_acc <= sum_acc + s_data;
      end else begin
        sum_acc <= sum_acc;
      end
    end

    assign cksum_bad = (sum_acc != sum_exp);
  end
`else
  assign cksum_bad = 1'b0;
`endif

  // Load sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      WADDR   <= '0;
      wbank   <= '0;
      WDATA   <= '0;
      WCLK    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b0;
          WCLK    <= 1'b0;
          busy    <= 1'b0;
          if (!abort && start) begin
            if (bank_sel == rbank) begin
              err <= 1'b1;
            end else begin
              wbank   <= bank_sel;
              WADDR   <= '0;
              s_ready <= 1'b1;
              busy    <= 1'b1;
              state   <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (abort) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            WADDR   <= '0;
            state   <= ST_IDLE;
          end else if (s_valid && s_ready) begin
            WDATA   <= s_data;
            WCLK    <= 1'b1;
            s_ready <= 1'b0;
            state   <= ST_WRITE;
          end
        end

        // WCLK is high for this whole cycle; address moves only as it falls.
        ST_WRITE: begin
          WCLK <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            WADDR <= '0;
            state <= ST_IDLE;
          end else if (WADDR == ADDR_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= cksum_bad;
            state <= ST_DONE;
          end else begin
            WADDR   <= WADDR + ADDR_ONE;
            s_ready <= 1'b1;
            state   <= ST_LOAD;
          end
        end

        ST_DONE: begin
          WADDR <= '0;
          state <= ST_IDLE;
        end

        default: begin
          s_ready <= 1'b0;
          WCLK    <= 1'b0;
          busy    <= 1'b0;
          WADDR   <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_loader.sv
// Self-checking bench for wavetable_loader: RAM writes are captured at the
// write strobe and compared with the sample stream the bench itself produced.
module tb_wavetable_loader;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int BW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] bank_sel;
  logic          abort;
  logic [BW-1:0] rbank;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] WADDR;
  logic [BW-1:0] wbank;
  logic [DW-1:0] WDATA;
  logic          WCLK;
  logic          busy;
  logic          done;
  logic          err;
`ifdef WAVETABLE_LOADER_CKSUM_EN
  logic [DW-1:0] cksum_exp;
`endif

  always #5 clk = ~clk;

  wavetable_loader dut (
    .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .abort(abort),
    .rbank(rbank), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .WADDR(WADDR), .wbank(wbank), .WDATA(WDATA), .WCLK(WCLK),
    .busy(busy), .done(done), .err(err)
`ifdef WAVETABLE_LOADER_CKSUM_EN
    , .cksum_exp(cksum_exp)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BW-1:0] b;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  int            wcyc[$];
  int            cyc = 0;
  int            done_n = 0;
  int            err_n = 0;
  int            done_cyc = -1;
  int            err_cyc = -1;
  logic [DW-1:0] samp[DEPTH];

  // Passive monitor: a RAM write happens for every cycle the strobe is high.
  always @(negedge clk) begin
    cyc++;
    if (WCLK === 1'b1) begin
      wq.push_back({wbank, WADDR, WDATA});
      wcyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    if (err === 1'b1) begin
      err_n++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wcyc.delete();
    done_n   = 0;
    err_n    = 0;
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic begin_load(input logic [BW-1:0] b);
    bank_sel = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Offers samp[0..n-1]; a sample advances only when valid meets ready.
  task automatic stream(input int n, input int valid_pct, input bit glitch_start);
    int  idx = 0;
    int  budget = 0;
    bit  acc;
    while (idx < n && budget < 4000) begin
      s_valid = ($urandom_range(99) < valid_pct);
      s_data  = samp[idx];
      if (glitch_start && idx == n / 2) begin
        start    = 1'b1;
        bank_sel = rbank;
      end else begin
        start = 1'b0;
      end
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
      budget++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("stream_accepts", idx, n);
  endtask

  // Expected RAM image: sample k lands at address k of bank b, in order.
  task automatic verify_writes(input string tag, input logic [BW-1:0] b, input int n);
    check({tag, "_nwrites"}, wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++) begin
      check({tag, "_bank"}, wq[k].b, b);
      check({tag, "_addr"}, wq[k].a, k);
      check({tag, "_data"}, wq[k].d, samp[k]);
    end
  endtask

  task automatic verify_done(input string tag);
    check({tag, "_done_n"}, done_n, 1);
    if (wcyc.size() > 0) check({tag, "_done_cyc"}, done_cyc, wcyc[wcyc.size()-1] + 1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int n_before;
    int budget;
    rst      = 1'b1;
    start    = 1'b0;
    bank_sel = '0;
    abort    = 1'b0;
    rbank    = '0;
    s_data   = '0;
    s_valid  = 1'b0;
`ifdef WAVETABLE_LOADER_CKSUM_EN
    cksum_exp = '0;
`endif
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_waddr", WADDR, 0);
    check("rst_wbank", wbank, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_wclk", WCLK, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_wclk_none", wq.size(), 0);

    // Full ramp into bank 1 at full rate.
    clear_log();
    for (int i = 0; i < DEPTH; i++) samp[i] = DW'(i);
    rbank = 2'd0;
    begin_load(2'd1);
    check("t1_busy", busy, 1'b1);
    check("t1_s_ready", s_ready, 1'b1);
    stream(DEPTH, 100, 1'b0);
    repeat (4) tick();
    verify_writes("t1", 2'd1, DEPTH);
    verify_done("t1");
    check("t1_err_n", err_n, 0);
    if (wcyc.size() == DEPTH) check("t1_rate", wcyc[DEPTH-1] - wcyc[0], 2 * (DEPTH - 1));
    check("t1_waddr_home", WADDR, 0);
    check("t1_wbank_hold", wbank, 2'd1);

    // Start into the bank being played is refused.
    clear_log();
    rbank    = 2'd2;
    bank_sel = 2'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("t2_err", err, 1'b1);
    check("t2_busy", busy, 1'b0);
    tick();
    check("t2_err_pulse", err, 1'b0);
    repeat (3) tick();
    check("t2_err_n", err_n, 1);
    check("t2_no_wclk", wq.size(), 0);

    // start and abort together in IDLE: nothing happens.
    clear_log();
    rbank    = 2'd0;
    bank_sel = 2'd1;
    start    = 1'b1;
    abort    = 1'b1;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    check("t2b_busy", busy, 1'b0);
    tick();
    check("t2b_err_n", err_n, 0);

    // Random data, bursty valid, stray start mid-load must be ignored.
    clear_log();
    for (int i = 0; i < DEPTH; i++) samp[i] = DW'($urandom);
    rbank = 2'd3;
    begin_load(2'd2);
    stream(DEPTH, 50, 1'b1);
    repeat (4) tick();
    verify_writes("t3", 2'd2, DEPTH);
    verify_done("t3");
    check("t3_err_n", err_n, 0);

    // Abort from WRITE after ten writes, then abort from LOAD.
    clear_log();
    for (int i = 0; i < DEPTH; i++) samp[i] = DW'($urandom);
    rbank = 2'd1;
    begin_load(2'd0);
    stream(10, 100, 1'b0);
    check("t4_in_write", WCLK, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    verify_writes("t4", 2'd0, 10);
    check("t4_done_n", done_n, 0);
    check("t4_busy", busy, 1'b0);
    begin_load(2'd0);
    s_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_load_abort_busy", busy, 1'b0);
    check("t4_load_abort_ready", s_ready, 1'b0);
    check("t4_load_abort_nw", wq.size(), 10);
    clear_log();
    begin_load(2'd0);
    stream(DEPTH, 80, 1'b0);
    repeat (4) tick();
    verify_writes("t4r", 2'd0, DEPTH);
    verify_done("t4r");

    // Reset while the write strobe is high.
    clear_log();
    rbank = 2'd0;
    begin_load(2'd3);
    s_valid = 1'b1;
    s_data  = 16'h5A5A;
    budget  = 0;
    while (WCLK !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    check("t5_saw_wclk", WCLK, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_wclk", WCLK, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_waddr", WADDR, 0);
    check("t5_s_ready", s_ready, 1'b0);
    n_before = wq.size();
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    s_valid = 1'b0;
    check("t5_no_more_writes", wq.size(), n_before);
    check("t5_busy_after", busy, 1'b0);

`ifdef WAVETABLE_LOADER_CKSUM_EN
    // Checksum match and mismatch on an all-ones table.
    for (int i = 0; i < DEPTH; i++) samp[i] = 16'h0001;
    clear_log();
    rbank     = 2'd0;
    cksum_exp = 16'h0100;
    begin_load(2'd1);
    cksum_exp = 16'h0000;
    stream(DEPTH, 100, 1'b0);
    repeat (4) tick();
    verify_done("t6a");
    check("t6a_err_n", err_n, 0);
    clear_log();
    cksum_exp = 16'h00FF;
    begin_load(2'd1);
    cksum_exp = 16'h0100;
    stream(DEPTH, 70, 1'b0);
    repeat (4) tick();
    verify_done("t6b");
    check("t6b_err_n", err_n, 1);
    check("t6b_err_with_done", err_cyc, done_cyc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
